// File: rtl/pfpu_vtxsink_pkg.sv
// Shared definitions for the PFPU vertex sink: address field layout,
// pairing-FSM encodings and the packed vertex record pushed into the FIFO.
package pfpu_vtxsink_pkg;

  // Wishbone bus widths.
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  // Byte-address field layout of a mesh write.
  localparam int WSEL_BIT = 2;   // 0 = first word (d1), 1 = second word (d2)
  localparam int X_LSB    = 3;   // [9:3]   mesh x
  localparam int Y_LSB    = 10;  // [16:10] mesh y
  localparam int WIN_LSB  = 17;  // [31:17] compared against the window base
  localparam int COORD_W  = 7;
  localparam int WIN_W    = ADR_W - WIN_LSB;

  // Pairing FSM encodings.
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HAVE_D1 = 1'b1;

  // One complete vertex: 7 + 7 + 32 + 32 bits.
  localparam int VTX_W = 78;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DAT_W-1:0]   d1;
    logic [DAT_W-1:0]   d2;
  } vtx_t;

  // Address field extractors.
  function automatic logic [COORD_W-1:0] adr_x(input logic [ADR_W-1:0] adr);
    return adr[X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] adr_y(input logic [ADR_W-1:0] adr);
    return adr[Y_LSB +: COORD_W];
  endfunction

  function automatic logic [WIN_W-1:0] adr_win(input logic [ADR_W-1:0] adr);
    return adr[ADR_W-1:WIN_LSB];
  endfunction

endpackage

// File: rtl/pfpu_vtxsink_if.sv
// Write-only Wibshbone-style slave port carrying the PFPU DMA mesh writes.
// The master (DMA) drives address, data and cycle/strobe; the sink acks.
interface pfpu_vtxsink_if;
  import pfpu_vtxsink_pkg::*;

  logic [ADR_W-1:0] wbs_adr_i;
  logic [DAT_W-1:0] wbs_dat_i;
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_ack_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_ack_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i,
    output wbs_ack_o
  );

endinterface

// File: rtl/pfpu_vtxsink_fifo.sv
// Synchronous show-ahead FIFO with a registered head. The head entry and its
// valid flag are registers, so the consumer sees glitch-free outputs; a push
// into an empty FIFO shows up on the head the following cycle.
module pfpu_vtxsink_fifo
  import pfpu_vtxsink_pkg::*;
#(
  parameter int depth_log2 = 3,
  parameter int width      = VTX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [width-1:0]      din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   count,
  output logic                  head_valid,
  output logic [width-1:0]      head
);

  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0] CNT_ONE  = (depth_log2+1)'(1);
  localparam logic [depth_log2:0] CNT_FULL = (depth_log2+1)'(DEPTH);

  logic [width-1:0]      mem [DEPTH];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2-1:0] rd_next;
  logic [depth_log2:0]   count_q;
  logic [depth_log2:0]   count_next;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & head_valid;
  assign rd_next = rd_ptr + 1'b1;

  // Occupancy after this cycle's push/pop.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    count_next = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  // Entry storage.
  // NOTE: the data array has no reset; only pointers and flags define what is valid, and a reset array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      count_q <= count_next;
    end
  end

  // Registered head: next entry from storage, or bypassed input data when
  // the FIFO is (or is about to be) empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (pop_ok) begin
        if (count_q > CNT_ONE) head <= mem[rd_next];
        else if (push_ok)      head <= din;
      end else if (empty && push_ok) begin
        head <= din;
      end
      head_valid <= (count_next != '0);
    end
  end

endmodule

// File: rtl/pfpu_vtxsink.sv
// PFPU DMA vertex sink. Pairs the two mesh words of each vertex (d1 at word
// offset 0, d2 at word offset 1), checks the window and pairing order, and
// queues completed vertices for a strobe/ack consumer. Acks for a completing
// word are withheld while the FIFO is full, back-pressuring the DMA.
module pfpu_vtxsink
  import pfpu_vtxsink_pkg::*;
#(
  parameter logic [WIN_W-1:0] adr_base        = 15'h0000,
  parameter int               fifo_depth_log2 = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  pfpu_vtxsink_if.slave      wb,
  output logic               vtx_stb_o,
  input  logic               vtx_ack_i,
  output logic [COORD_W-1:0] vtx_x,
  output logic [COORD_W-1:0] vtx_y,
  output logic [DAT_W-1:0]   vtx_d1,
  output logic [DAT_W-1:0]   vtx_d2,
  input  logic               clr,
  output logic [15:0]        vtx_count,
  output logic               err_order,
  output logic               err_window
);

  // Registered bus/FSM state.
  logic               ack_q;
  logic [0:0]         state_q;
  logic [COORD_W-1:0] hold_x;
  logic [COORD_W-1:0] hold_y;
  logic [DAT_W-1:0]   hold_d1;

  // Decode results.
  logic               req;
  logic               in_window;
  logic               wsel;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               xy_match;
  logic               ack_d;
  logic [0:0]         state_d;
  logic               latch_d1;
  logic               push;
  logic               set_order;
  logic               set_window;
  vtx_t               push_vtx;

  // FIFO side.
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [fifo_depth_log2:0] fifo_count;
  logic [VTX_W-1:0]         head_bits;
  vtx_t                     head;

  // A request is live only while not already being acked, which keeps acks
  // one cycle wide and never back-to-back.
  assign req       = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
  assign in_window = (adr_win(wb.wbs_adr_i) == adr_base);
  assign wsel      = wb.wbs_adr_i[WSEL_BIT];
  assign req_x     = adr_x(wb.wbs_adr_i);
  assign req_y     = adr_y(wb.wbs_adr_i);
  assign xy_match  = (req_x == hold_x) && (req_y == hold_y);

  // Classify the current request and decide ack, FSM move and side effects.
  always_comb begin
    ack_d      = 1'b0;
    state_d    = state_q;
    latch_d1   = 1'b0;
    push       = 1'b0;
    set_order  = 1'b0;
    set_window = 1'b0;
    if (req) begin
      if (!in_window) begin
        // Outside the mesh window: ack and drop, pairing state untouched.
        ack_d      = 1'b1;
        set_window = 1'b1;
      end else if (!wsel) begin
        // First word always (re)loads the holding register; a pending d1
        // being overwritten is an order error.
        ack_d     = 1'b1;
        latch_d1  = 1'b1;
        set_order = (state_q == HAVE_D1);
        state_d   = HAVE_D1;
      end else if ((state_q == HAVE_D1) && xy_match) begin
        // Completing word: stall (no ack) until the FIFO has room.
        if (!fifo_full) begin
          ack_d   = 1'b1;
          push    = 1'b1;
          state_d = IDLE;
        end
      end else begin
        // Orphan or mismatched second word.
        ack_d     = 1'b1;
        set_order = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  // Vertex assembled from the holding register and the second word.
  always_comb begin
    push_vtx.x  = hold_x;
    push_vtx.y  = hold_y;
    push_vtx.d1 = hold_d1;
    push_vtx.d2 = wb.wbs_dat_i;
  end

  // Ack, pairing FSM and holding register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ack_q   <= 1'b0;
      state_q <= IDLE;
      hold_x  <= '0;
      hold_y  <= '0;
      hold_d1 <= '0;
    end else begin
      ack_q   <= ack_d;
      state_q <= state_d;
      if (latch_d1) begin
        hold_x  <= req_x;
        hold_y  <= req_y;
        hold_d1 <= wb.wbs_dat_i;
      end
    end
  end

  // Vertex counter and sticky error flags; clr wins over a same-cycle update.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vtx_count  <= '0;
      err_order  <= 1'b0;
      err_window <= 1'b0;
    end else if (clr) begin
      vtx_count  <= '0;
      err_order  <= 1'b0;
      err_window <= 1'b0;
    end else begin
      if (push)       vtx_count  <= vtx_count + 16'd1;
      if (set_order)  err_order  <= 1'b1;
      if (set_window) err_window <= 1'b1;
    end
  end

  pfpu_vtxsink_fifo #(
    .depth_log2 (fifo_depth_log2),
    .width      (VTX_W)
  ) u_fifo (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .push       (push),
    .din        (push_vtx),
    .pop        (vtx_ack_i),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_valid (vtx_stb_o),
    .head       (head_bits)
  );

  assign head         = vtx_t'(head_bits);
  assign wb.wbs_ack_o = ack_q;
  assign vtx_x        = head.x;
  assign vtx_y        = head.y;
  assign vtx_d1       = head.d1;
  assign vtx_d2       = head.d2;

  // Byte-lane bits and FIFO status not needed by this block.
  logic unused;
  assign unused = ^{wb.wbs_adr_i[1:0], fifo_empty, fifo_count};

endmodule

// File: doc/pfpu_vtxsink.md
Name: pfpu_vtxsink

Overview:
Wishbone write-only slave that receives the PFPU DMA mesh writes, sel=1111, no wbs_we_i. Each vertex arrives as two words: d1 at word offset 0 and d2 at word offset 1. The block pairs d1 with d2, decodes x/y from the address and pushes complete vertices into a FIFO. The FIFO drives a strobe/ack vertex stream toward a downstream consumer such as the texture mapping unit. Acks are withheld when the FIFO is full, so PFPU DMA back-pressure comes from here.

Parameters:
adr_base, 15'h0000, compared against wbs_adr_i[31:17]; selects the 128 KB mesh window.
fifo_depth_log2, 3, FIFO depth = 2^fifo_depth_log2 vertices.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
wbs_adr_i  in  32  byte address; [2]=word select, [9:3]=x, [16:10]=y
wbs_dat_i  in  32  write data
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_ack_o  out  1  registered single-cycle ack
vtx_stb_o  out  1  vertex valid
vtx_ack_i  in  1  consumer accepts the head vertex
vtx_x  out  7  head vertex x
vtx_y  out  7  head vertex y
vtx_d1  out  32  head vertex first word
vtx_d2  out  32  head vertex second word
clr  in  1  clears vtx_count, err_order and err_window
vtx_count  out  16  vertices pushed; wraps from 16'hFFFF to 0
err_order  out  1  sticky protocol-order error
err_window  out  1  sticky out-of-window error

Behaviour:
- Reset values: wbs_ack_o=0, vtx_stb_o=0, vtx_x/y/d1/d2=0, vtx_count=0, err_order=0, err_window=0. State=IDLE, FIFO empty, holding register cleared.
- Request: req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o. When a request is accepted, wbs_ack_o is 1 for exactly the next cycle. Minimum latency is 1 cycle, and no two acks occur back-to-back.
- Window check: if adr[31:17] != adr_base, the write is acked next cycle and dropped. err_window is set and state is unchanged.
- States: IDLE and HAVE_D1. The holding register stores d1, x and y.
- Word0 (adr[2]=0) in IDLE: latch d1/x/y, ack, go to HAVE_D1.
- Word0 in HAVE_D1: overwrite the holding register, ack, set err_order, stay in HAVE_D1.
- Word1 (adr[2]=1) in HAVE_D1 with matching x/y, FIFO not full: push {x,y,d1,d2}, ack, go to IDLE, increment vtx_count.
- Word1 in HAVE_D1 with matching x/y, FIFO full: no ack; the request stays pending and is re-evaluated every cycle.
- Word1 in IDLE, or with x/y mismatch: ack, drop, set err_order, go to IDLE.
- Full flag: "full" is taken from the registered FIFO count. A pop in the same cycle does not allow a push that cycle; the push happens the cycle after, and the ack the cycle after the push.
- Simultaneous push and pop when not full: count unchanged, data ordering preserved.
- Output stream: FIFO is show-ahead with registered outputs. vtx_stb_o rises the cycle after a push into an empty FIFO. Pop when vtx_stb_o & vtx_ack_i; the next head appears on the following cycle. vtx_x/y/d1/d2 are stable while vtx_stb_o=1 and vtx_ack_i=0.
- Deassertion of wbs_cyc_i while a request is stalled cancels it: nothing is acked and nothing is pushed.
- clr: has priority over a same-cycle increment or error set, so the result is 0 in that cycle. clr does not touch the FIFO or state.
- Reset mid-operation: the holding register and FIFO contents are lost, and any pending request gets no ack. A word1 following reset is an order error.

Decomposition:
- Shared package holds:
  - address field constants: WSEL_BIT=2, X_LSB=3, Y_LSB=10, WIN_LSB=17;
  - state encodings IDLE/HAVE_D1;
  - vertex width constant 78 = 7+7+32+32.
- One sub-module: pfpu_vtxsink_fifo, a synchronous show-ahead FIFO with registered count, full, empty, push and pop.

Test Plan:
- Single vertex, adr_base=0: write adr 0x1418 d=0x3F800000, then adr 0x141C d=0x40000000. Each is acked 1 cycle later. Expect vtx_stb_o=1 with x=3, y=5, d1=0x3F800000, d2=0x40000000, vtx_count=1.
- Back-pressure, depth 8: hold vtx_ack_i=0 and send 9 vertices. The 9th word1 is not acked. Pulse vtx_ack_i once; the 9th is pushed the cycle after the count updates and acked the cycle after that. Drain and check order x=0..8.
- Order error: word1 at adr 0x0004 with no prior word0. Expect ack, err_order=1, vtx_count=0, no vtx_stb_o.
- Window: write adr 0x00020000 with adr_base=0. Expect ack, err_window=1, state unchanged, nothing pushed.
- Reset mid-vertex: word0 acked, assert sys_rst for 1 cycle, then matching word1. Expect all outputs at reset values, then ack, err_order=1, vtx_count=0.
- clr coincident with a push: expect vtx_count=0, the vertex still present at the FIFO head, and the errors cleared.
